// File: rtl/alu_issue_stage_pkg.sv
// Shared encodings for the ALU issue stage: ALU selects, RV32I opcodes,
// buffer states and the decoded-operation bundle handed from decode to issue.
package alu_issue_stage_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_LTU   = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_EQ    = 4'b1111;
    localparam logic [3:0] ALU_PASSB = 4'b1000;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [31:0] SIGN_FLIP = 32'h8000_0000;

    typedef struct packed {
        logic [3:0]  alu_sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        reg_write;
        logic        is_branch;
        logic        br_invert;
        logic        illegal;
    } dec_t;

    localparam int DEC_W = $bits(dec_t);

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Combinational RV32I decode: instruction plus register operands in,
// ALU select, biased operand pair and write-back/branch flags out.
module rv32_alu_decode
    import alu_issue_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SIGNED_BIAS = 1
) (
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    output dec_t              dec
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] u_imm;
    logic        legal;
    logic        signed_cmp;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign i_imm  = {{20{instr[31]}}, instr[31:20]};
    assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign u_imm  = {instr[31:12], 12'b0};

    always_comb begin
        dec        = '0;
        legal      = 1'b1;
        signed_cmp = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                dec.a         = rs1_data;
                dec.b         = (opcode == OPC_OP) ? rs2_data : i_imm;
                dec.rd        = instr[11:7];
                dec.reg_write = 1'b1;
                case (f3)
                    3'b000: dec.alu_sel = (opcode == OPC_OP && instr[30]) ? ALU_SUB : ALU_ADD;
                    3'b111: dec.alu_sel = ALU_AND;
                    3'b110: dec.alu_sel = ALU_OR;
                    3'b010: begin
                        dec.alu_sel = ALU_LTU;
                        signed_cmp  = 1'b1;
                    end
                    3'b011: dec.alu_sel = ALU_LTU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                dec.alu_sel   = ALU_PASSB;
                dec.b         = u_imm;
                dec.rd        = instr[11:7];
                dec.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                dec.alu_sel   = ALU_ADD;
                dec.a         = rs1_data;
                dec.b         = i_imm;
                dec.rd        = instr[11:7];
                dec.reg_write = 1'b1;
            end
            OPC_STORE: begin
                // Instr[11:7] is immediate here, so no destination is reported.
                dec.alu_sel = ALU_ADD;
                dec.a       = rs1_data;
                dec.b       = s_imm;
            end
            OPC_BRANCH: begin
                dec.a         = rs1_data;
                dec.b         = rs2_data;
                dec.is_branch = 1'b1;
                dec.br_invert = instr[12];
                case (f3)
                    3'b000, 3'b001: dec.alu_sel = ALU_EQ;
                    3'b100, 3'b101: begin
                        dec.alu_sel = ALU_LTU;
                        signed_cmp  = 1'b1;
                    end
                    3'b110, 3'b111: dec.alu_sel = ALU_LTU;
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        // Flipping the sign bits turns the ALU's unsigned A<B into a signed compare.
        if (legal && signed_cmp && (SIGNED_BIAS != 0)) begin
            dec.a = dec.a ^ SIGN_FLIP;
            dec.b = dec.b ^ SIGN_FLIP;
        end

        if (!legal) begin
            dec         = '0;
            dec.alu_sel = ALU_PASSB;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue slot: decodes an instruction and holds it in a two-entry skid
// buffer (main = visible slot, skid = overflow) in front of the ALU.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SIGNED_BIAS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [31:0]       Instr,
    input  logic [DATA_W-1:0] RS1_Data,
    input  logic [DATA_W-1:0] RS2_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [3:0]        ALU_Sel,
    output logic [DATA_W-1:0] A_out,
    output logic [DATA_W-1:0] B_out,
    output logic [4:0]        Rd,
    output logic              Reg_Write,
    output logic              Is_Branch,
    output logic              Br_Invert,
    output logic              Illegal,
    output logic [1:0]        dbg_state
);

    // Handshake: a word moves on a rising edge where its side's valid and ready
    // are both high; valid never depends on ready, and Out_* hold while stalled.

    dec_t       dec;
    dec_t       main_q;
    dec_t       skid_q;
    buf_state_t state;
    logic       accept;
    logic       drain;

    rv32_alu_decode #(
        .DATA_W      (DATA_W),
        .SIGNED_BIAS (SIGNED_BIAS)
    ) u_decode (
        .instr    (Instr),
        .rs1_data (RS1_Data),
        .rs2_data (RS2_Data),
        .dec      (dec)
    );

    assign Out_Valid = (state != BUF_EMPTY);
    assign accept    = In_Valid & In_Ready & ~Flush;
    assign drain     = Out_Valid & Out_Ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BUF_EMPTY;
            In_Ready <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (Flush) begin
            // A word draining this cycle is already delivered; everything else goes.
            state    <= BUF_EMPTY;
            In_Ready <= 1'b1;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        main_q <= dec;
                        state  <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (accept && !drain) begin
                        skid_q   <= dec;
                        state    <= BUF_TWO;
                        In_Ready <= 1'b0;
                    end else if (drain && !accept) begin
                        state <= BUF_EMPTY;
                    end else if (drain && accept) begin
                        main_q <= dec;
                    end
                end
                BUF_TWO: begin
                    if (drain) begin
                        main_q   <= skid_q;
                        state    <= BUF_ONE;
                        In_Ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= BUF_EMPTY;
                    In_Ready <= 1'b1;
                end
            endcase
        end
    end

    assign ALU_Sel   = main_q.alu_sel;
    assign A_out     = main_q.a;
    assign B_out     = main_q.b;
    assign Rd        = main_q.rd;
    assign Reg_Write = main_q.reg_write;
    assign Is_Branch = main_q.is_branch;
    assign Br_Invert = main_q.br_invert;
    assign Illegal   = main_q.illegal;
    assign dbg_state = state;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus random traffic, checked
// by a scoreboard fed from an instruction-level reference model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Flush = 1'b0;
    logic        In_Valid = 1'b0;
    logic        Out_Ready = 1'b0;
    logic [31:0] Instr = '0;
    logic [31:0] RS1_Data = '0;
    logic [31:0] RS2_Data = '0;
    logic        In_Ready, Out_Valid;
    logic [3:0]  ALU_Sel;
    logic [31:0] A_out, B_out;
    logic [4:0]  Rd;
    logic        Reg_Write, Is_Branch, Br_Invert, Illegal;
    logic [1:0]  dbg_state;

    alu_issue_stage #(.DATA_W(32), .SIGNED_BIAS(1)) dut (
        .clk(clk), .reset(reset), .Flush(Flush), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Instr(Instr), .RS1_Data(RS1_Data), .RS2_Data(RS2_Data), .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready), .ALU_Sel(ALU_Sel), .A_out(A_out), .B_out(B_out), .Rd(Rd),
        .Reg_Write(Reg_Write), .Is_Branch(Is_Branch), .Br_Invert(Br_Invert),
        .Illegal(Illegal), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wr;
        logic        br;
        logic        inv;
        logic        ill;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    typedef enum {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLTU, M_LUI, M_LOAD, M_STORE,
                  M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU, M_BAD} mn_t;

    function automatic mn_t classify(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        case (ins[6:0])
            7'h33, 7'h13: begin
                case (f3)
                    3'd0: return (ins[6:0] == 7'h33 && ins[30]) ? M_SUB : M_ADD;
                    3'd7: return M_AND;
                    3'd6: return M_OR;
                    3'd2: return M_SLT;
                    3'd3: return M_SLTU;
                    default: return M_BAD;
                endcase
            end
            7'h37: return M_LUI;
            7'h03: return M_LOAD;
            7'h23: return M_STORE;
            7'h63: begin
                case (f3)
                    3'd0: return M_BEQ;
                    3'd1: return M_BNE;
                    3'd4: return M_BLT;
                    3'd5: return M_BGE;
                    3'd6: return M_BLTU;
                    3'd7: return M_BGEU;
                    default: return M_BAD;
                endcase
            end
            default: return M_BAD;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs1,
                                   input logic [31:0] rs2);
        exp_t e;
        mn_t m;
        logic [31:0] imm_i, imm_s;
        m = classify(ins);
        e = '0;
        imm_i = 32'($signed(ins[31:20]));
        imm_s = 32'($signed({ins[31:25], ins[11:7]}));
        if (m == M_BAD) begin
            e.sel = 4'b1000;
            e.ill = 1'b1;
            return e;
        end
        e.a = rs1;
        e.b = (ins[6:0] == 7'h13) ? imm_i : rs2;
        e.rd = ins[11:7];
        e.wr = 1'b1;
        case (m)
            M_ADD:        e.sel = 4'b0010;
            M_SUB:        e.sel = 4'b0110;
            M_AND:        e.sel = 4'b0000;
            M_OR:         e.sel = 4'b0001;
            M_SLT, M_SLTU: e.sel = 4'b0111;
            M_LUI: begin
                e.sel = 4'b1000;
                e.a = 32'd0;
                e.b = {ins[31:12], 12'h000};
            end
            M_LOAD: begin
                e.sel = 4'b0010;
                e.b = imm_i;
            end
            M_STORE: begin
                e.sel = 4'b0010;
                e.b = imm_s;
                e.rd = 5'd0;
                e.wr = 1'b0;
            end
            default: begin
                e.sel = (m == M_BEQ || m == M_BNE) ? 4'b1111 : 4'b0111;
                e.rd = 5'd0;
                e.wr = 1'b0;
                e.br = 1'b1;
                e.inv = (m == M_BNE || m == M_BGE || m == M_BGEU);
            end
        endcase
        if (m == M_SLT || m == M_BLT || m == M_BGE) begin
            e.a = e.a + 32'h8000_0000;
            e.b = e.b + 32'h8000_0000;
        end
        return e;
    endfunction

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t observed();
        exp_t o;
        o = '{sel: ALU_Sel, a: A_out, b: B_out, rd: Rd, wr: Reg_Write,
              br: Is_Branch, inv: Br_Invert, ill: Illegal};
        return o;
    endfunction

    // Accept tracker: pushes the model's answer for every accepted input.
    always @(negedge clk) begin
        logic acc;
        exp_t e;
        acc = !reset && In_Valid && In_Ready && !Flush;
        e = model(Instr, RS1_Data, RS2_Data);
        #2;
        if (acc) exp_q.push_back(e);
    end

    // Monitor: occupancy, stability while stalled, and in-order delivery.
    logic       held = 1'b0;
    exp_t       held_v;
    always @(negedge clk) begin
        if (reset) begin
            held = 1'b0;
        end else begin
            check("out_valid_vs_occupancy", 80'(Out_Valid), 80'(exp_q.size() > 0));
            check("in_ready_vs_occupancy", 80'(In_Ready), 80'(exp_q.size() < 2));
            if (Out_Valid && held) check("held_stable", 80'(observed()), 80'(held_v));
            if (Out_Valid && Out_Ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%h required=none t=%0t",
                             observed(), $time);
                end else begin
                    check("transfer", 80'(observed()), 80'(exp_q.pop_front()));
                end
            end
            held = Out_Valid && !Out_Ready;
            held_v = observed();
            if (Flush) exp_q.delete();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2);
        Instr = ins;
        RS1_Data = rs1;
        RS2_Data = rs2;
        In_Valid = 1'b1;
    endtask

    // Presents one instruction and returns 1ns after the edge that accepted it.
    task automatic issue(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2);
        set_in(ins, rs1, rs2);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (In_Ready) begin
                @(posedge clk);
                #1;
                In_Valid = 1'b0;
                return;
            end
        end
        check("issue_timeout", 80'(0), 80'(1));
        In_Valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0] opc;
        r = $urandom;
        case ($urandom_range(0, 6))
            0: opc = 7'h33;
            1: opc = 7'h13;
            2: opc = 7'h37;
            3: opc = 7'h03;
            4: opc = 7'h23;
            5: opc = 7'h63;
            default: opc = 7'($urandom_range(0, 127));
        endcase
        return {r[31:7], opc};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 80'(Out_Valid), 80'(0));
        check({tag, "_in_ready"}, 80'(In_Ready), 80'(1));
        check({tag, "_outputs"}, 80'(observed()), 80'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2 reset = 1'b1;
        #1 check_reset_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed decodes, consumer always ready.
        Out_Ready = 1'b1;
        issue(32'h002081B3, 32'd5, 32'd7);
        check("add_valid", 80'(Out_Valid), 80'(1));
        check("add_sel", 80'(ALU_Sel), 80'(4'b0010));
        check("add_ab", 80'({A_out, B_out}), 80'({32'd5, 32'd7}));
        check("add_rd_wr", 80'({Rd, Reg_Write}), 80'({5'd3, 1'b1}));
        issue(32'h402081B3, 32'd5, 32'd7);
        check("sub_sel", 80'(ALU_Sel), 80'(4'b0110));
        issue(32'hFFF00093, 32'd0, 32'd0);
        check("addi_sel_b_rd", 80'({ALU_Sel, B_out, Rd}), 80'({4'b0010, 32'hFFFF_FFFF, 5'd1}));
        issue(32'h0020C063, 32'hFFFF_FFFF, 32'd1);
        check("blt_sel", 80'(ALU_Sel), 80'(4'b0111));
        check("blt_ab", 80'({A_out, B_out}), 80'({32'h7FFF_FFFF, 32'h8000_0001}));
        check("blt_flags", 80'({Is_Branch, Br_Invert, Reg_Write}), 80'(3'b100));
        issue(32'h0000007F, 32'd9, 32'd9);
        check("illegal_flags", 80'({Illegal, ALU_Sel, Reg_Write}), 80'({1'b1, 4'b1000, 1'b0}));
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: two accepted, third stalls, then drain in order.
        Out_Ready = 1'b0;
        set_in(32'h002081B3, 32'd11, 32'd1);
        @(posedge clk); #1;
        set_in(32'h002081B3, 32'd22, 32'd2);
        @(posedge clk); #1;
        check("bp_full_ready", 80'(In_Ready), 80'(0));
        set_in(32'h002081B3, 32'd33, 32'd3);
        @(posedge clk); #1;
        check("bp_still_full", 80'(In_Ready), 80'(0));
        check("bp_head", 80'(A_out), 80'(32'd11));
        @(posedge clk); #1;
        Out_Ready = 1'b1;
        issue(32'h002081B3, 32'd33, 32'd3);
        repeat (4) @(posedge clk);
        #1;

        // Flush while full with a word offered: nothing stale may emerge.
        Out_Ready = 1'b0;
        set_in(32'h0020F1B3, 32'hAAAA_0000, 32'h0000_FFFF);
        @(posedge clk); #1;
        set_in(32'h0020E1B3, 32'h1234_5678, 32'h1);
        @(posedge clk); #1;
        set_in(32'h002081B3, 32'd77, 32'd1);
        Flush = 1'b1;
        @(posedge clk); #1;
        Flush = 1'b0;
        In_Valid = 1'b0;
        check("flush_out_valid", 80'(Out_Valid), 80'(0));
        check("flush_in_ready", 80'(In_Ready), 80'(1));
        Out_Ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Random traffic with random backpressure and occasional flush.
        for (int c = 0; c < 600; c++) begin
            Instr = rand_instr();
            RS1_Data = $urandom;
            RS2_Data = ($urandom_range(0, 3) == 0) ? RS1_Data : $urandom;
            In_Valid = ($urandom_range(0, 3) != 0);
            Out_Ready = ($urandom_range(0, 2) != 0);
            Flush = ($urandom_range(0, 40) == 0);
            @(posedge clk); #1;
        end
        Flush = 1'b0;

        // Fill the buffer, then reset asynchronously between edges.
        Out_Ready = 1'b0;
        In_Valid = 1'b1;
        Instr = 32'h002081B3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #3 reset = 1'b1;
        exp_q.delete();
        #1 check_reset_outputs("midreset");
        @(posedge clk);
        #1 reset = 1'b0;
        In_Valid = 1'b0;

        // Post-reset traffic and final drain.
        Out_Ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            Instr = rand_instr();
            RS1_Data = $urandom;
            RS2_Data = $urandom;
            In_Valid = ($urandom_range(0, 1) != 0);
            Out_Ready = ($urandom_range(0, 1) != 0);
            @(posedge clk); #1;
        end
        In_Valid = 1'b0;
        Out_Ready = 1'b1;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("drained_empty", 80'(exp_q.size()), 80'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
